fp_sub_seq: RTL and testbench



---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_align_shift.sv | 53 +++++
 rtl/fp_sub_seq.sv | 174 +++++++++++++++++
 tb/tb_fp_sub_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the sequential single-precision subtractor:
//   - field widths and exponent constants for IEEE-754 single precision
//   - fp32_t : packed field view {sign, exp, man} of a 32-bit float
//   - state_t : FSM state encoding of fp_sub_seq
//   - is_zero() : true for +/-0.0 (no hidden bit)
// ---------------------------------------------------------------------------
package fp_pkg;

   localparam int EXP_W  = 8;
   localparam int MAN_W  = 23;
   localparam int FP_W   = 1 + EXP_W + MAN_W;
   localparam int WORK_W = MAN_W + 1;      // mantissa including hidden bit
   localparam int BIAS   = 127;

   localparam logic [EXP_W-1:0] EXP_MAX = '1;                 // 255
   localparam logic [EXP_W-1:0] EXP_TOP = EXP_MAX - 1'b1;     // 254, largest finite
   localparam logic [EXP_W-1:0] EXP_ONE = 1;
   localparam logic [FP_W-1:0]  ZERO    = '0;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp32_t;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADD,
      NORM,
      DONE
   } state_t;

   function automatic logic is_zero(input fp32_t x);
      return (x.exp == '0) && (x.man == '0);
   endfunction

endpackage

// File: rtl/fp_align_shift.sv
// ---------------------------------------------------------------------------
// fp_align_shift
// Combinational operand alignment for the subtractor's ALIGN state.
// Orders the two operands by magnitude ({exp,man}), attaches the hidden bit
// (none for a zero operand) and right-shifts the smaller mantissa by the
// exponent difference. Shifts of WORK_W or more saturate to zero; bits
// shifted out are simply dropped (truncation).
// Ports:
//   a, b    in  operands (b already sign-flipped by the caller)
//   sign_l  out sign of the larger-magnitude operand
//   sign_s  out sign of the smaller-magnitude operand
//   exp_l   out exponent of the larger operand
//   man_l   out larger mantissa with hidden bit
//   man_s   out smaller mantissa with hidden bit, aligned to exp_l
// ---------------------------------------------------------------------------
module fp_align_shift
   import fp_pkg::*;
(
   input  fp32_t             a,
   input  fp32_t             b,
   output logic              sign_l,
   output logic              sign_s,
   output logic [EXP_W-1:0]  exp_l,
   output logic [WORK_W-1:0] man_l,
   output logic [WORK_W-1:0] man_s
);

   localparam logic [EXP_W-1:0] SHIFT_SAT = EXP_W'(WORK_W);

   fp32_t              l_op;
   fp32_t              s_op;
   logic               swap;
   logic [EXP_W-1:0]   diff;
   logic [WORK_W-1:0]  man_s_full;

   // NOTE: every variable is assigned unconditionally before any branch, so
   // this block stays purely combinational and no latch is inferred.
   always_comb begin
      // On equal magnitude a stays the larger operand.
      swap       = {b.exp, b.man} > {a.exp, a.man};
      l_op       = swap ? b : a;
      s_op       = swap ? a : b;
      diff       = l_op.exp - s_op.exp;

      sign_l     = l_op.sign;
      sign_s     = s_op.sign;
      exp_l      = l_op.exp;
      man_l      = is_zero(l_op) ? '0 : {1'b1, l_op.man};
      man_s_full = is_zero(s_op) ? '0 : {1'b1, s_op.man};
      man_s      = (diff >= SHIFT_SAT) ? '0 : (man_s_full >> diff);
   end

endmodule

// File: rtl/fp_sub_seq.sv
// ---------------------------------------------------------------------------
// fp_sub_seq
// Multi-cycle IEEE-754 single-precision subtractor, result = a - b.
// Computed as a + (-b); normalisation shifts one bit per cycle in NORM.
// done and result are registered on the clock edge that leaves DONE, so done
// is a one-cycle pulse while the FSM is already back in IDLE.
// Latency from the edge sampling start to the done-high cycle:
//   3 for a zero sum, 4 + k otherwise (k = left shifts, 0..23).
// Ports:
//   clk     in  rising-edge clock
//   rst     in  synchronous active-high reset; aborts any operation
//   start   in  request pulse, sampled only in IDLE
//   a       in  minuend (IEEE-754 single)
//   b       in  subtrahend (IEEE-754 single)
//   busy    out high in every state except IDLE
//   done    out one-cycle pulse, result valid from this cycle
//   result  out a - b, held until the next done
// ---------------------------------------------------------------------------
module fp_sub_seq
   import fp_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [FP_W-1:0] result
);

   state_t              state;
   state_t              next_state;

   // Working datapath registers
   fp32_t               op_a;
   fp32_t               op_b;
   logic                sign_w;
   logic                sign_s;
   logic [EXP_W-1:0]    exp_w;
   logic [WORK_W-1:0]   man_l_r;
   logic [WORK_W-1:0]   man_s_r;
   logic [WORK_W:0]     sum_r;       // bit WORK_W is the addition carry

   // Alignment results
   logic                al_sign_l;
   logic                al_sign_s;
   logic [EXP_W-1:0]    al_exp_l;
   logic [WORK_W-1:0]   al_man_l;
   logic [WORK_W-1:0]   al_man_s;

   logic [WORK_W:0]     add_sum;
   logic                norm_carry;
   logic                norm_ok;
   logic                norm_underflow;

   fp_align_shift u_align (
      .a      (op_a),
      .b      (op_b),
      .sign_l (al_sign_l),
      .sign_s (al_sign_s),
      .exp_l  (al_exp_l),
      .man_l  (al_man_l),
      .man_s  (al_man_s)
   );

   // Magnitude add/subtract of the aligned mantissas; mL >= mS so the
   // difference never goes negative.
   always_comb begin
      if (sign_w == sign_s)
         add_sum = {1'b0, man_l_r} + {1'b0, man_s_r};
      else
         add_sum = {1'b0, man_l_r} - {1'b0, man_s_r};
   end

   // Normalisation decisions for the current NORM cycle.
   always_comb begin
      norm_carry     = sum_r[WORK_W];
      norm_ok        = sum_r[WORK_W-1];
      // A further left shift would take the exponent below 1.
      norm_underflow = !norm_carry && !norm_ok && (exp_w <= EXP_ONE);
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = ALIGN;
         ALIGN:   next_state = ADD;
         ADD:     next_state = (add_sum == '0) ? DONE : NORM;
         NORM:    if (norm_carry || norm_ok || norm_underflow) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = (state != IDLE);
   end

   // Datapath. A reset abandons the operation and IDLE reloads every register
   // before it is read again, so these need no reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before this clock edge.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (start) begin
               op_a <= fp32_t'(a);
               op_b <= fp32_t'({~b[FP_W-1], b[FP_W-2:0]});
            end
         end
         ALIGN: begin
            sign_w  <= al_sign_l;
            sign_s  <= al_sign_s;
            exp_w   <= al_exp_l;
            man_l_r <= al_man_l;
            man_s_r <= al_man_s;
         end
         ADD: begin
            if (add_sum == '0) begin
               // Exact cancellation always yields positive zero.
               sign_w <= 1'b0;
               exp_w  <= '0;
               sum_r  <= '0;
            end else begin
               sum_r  <= add_sum;
            end
         end
         NORM: begin
            if (norm_carry) begin
               if (exp_w == EXP_TOP) begin
                  exp_w <= EXP_MAX;          // overflow to signed infinity
                  sum_r <= '0;
               end else begin
                  exp_w <= exp_w + EXP_ONE;
                  sum_r <= sum_r >> 1;
               end
            end else if (!norm_ok) begin
               if (norm_underflow) begin
                  exp_w <= '0;               // flush to signed zero
                  sum_r <= '0;
               end else begin
                  exp_w <= exp_w - EXP_ONE;
                  sum_r <= sum_r << 1;
               end
            end
         end
         default: ;
      endcase
   end

   // Output registers: only the DONE state updates them.
   always_ff @(posedge clk) begin
      if (rst) begin
         done   <= 1'b0;
         result <= ZERO;
      end else begin
         done <= (state == DONE);
         if (state == DONE)
            result <= {sign_w, exp_w, sum_r[MAN_W-1:0]};
      end
   end

endmodule

// File: tb/tb_fp_sub_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_sub_seq
// Self-checking bench for fp_sub_seq. Each operation pushes its expected
// result and latency into a scoreboard queue when start is driven; the entry
// is popped and compared when done rises.
// ---------------------------------------------------------------------------
module tb_fp_sub_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] res;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];

   fp_sub_seq dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   // Drive one start pulse; returns 1 time unit after the sampling edge.
   task automatic issue(input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] res, input int lat, input string name);
      exp_t e;
      e.res  = res;
      e.lat  = lat;
      e.name = name;
      sb.push_back(e);
      @(negedge clk);
      a     = op_a;
      b     = op_b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Wait for done (bounded), pop the scoreboard and compare. Optionally
   // pulses start with other operands inject_at cycles after the sampling edge.
   task automatic collect(input int inject_at, input logic [31:0] inj_a,
                          input logic [31:0] inj_b);
      exp_t e;
      int   cyc     = 0;
      bit   seen    = 0;
      bit   busy_ok = 1;
      e = sb.pop_front();
      while (!seen && cyc < 60) begin
         if (done === 1'b1) begin
            seen = 1;
         end else begin
            if (busy !== 1'b1) busy_ok = 0;
            if (cyc == inject_at) begin
               a     = inj_a;
               b     = inj_b;
               start = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            cyc++;
         end
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s_timeout: no done within %0d cycles", e.name, cyc);
      end else begin
         tests++;
         if (result !== e.res) begin
            fails++;
            $display("FAIL %s_result: got %h expected %h", e.name, result, e.res);
         end
         tests++;
         if (cyc !== e.lat) begin
            fails++;
            $display("FAIL %s_latency: got %0d expected %0d", e.name, cyc, e.lat);
         end
         tests++;
         if (!busy_ok) begin
            fails++;
            $display("FAIL %s_busy: busy got 0 expected 1 before done", e.name);
         end
         @(posedge clk);
         #1;
         tests++;
         if (done !== 1'b0) begin
            fails++;
            $display("FAIL %s_done_pulse: done got %b expected 0", e.name, done);
         end
      end
   endtask

   task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic [31:0] res, input int lat, input string name);
      issue(op_a, op_b, res, lat, name);
      collect(-1, 32'h0, 32'h0);
   endtask

   // Counts done pulses over a window; any pulse is a failure.
   task automatic expect_quiet(input int ncyc, input string name);
      int pulses = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) pulses++;
      end
      tests++;
      if (pulses != 0) begin
         fails++;
         $display("FAIL %s: done pulses got %0d expected 0", name, pulses);
      end
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      start = 1'b0;
      a     = 32'h0;
      b     = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL reset_done: got %b expected 0", done);
      end
      tests++;
      if (result !== 32'h0) begin
         fails++;
         $display("FAIL reset_result: got %h expected 00000000", result);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic;
      run_op(32'h40400000, 32'h3F800000, 32'h40000000, 4, "three_minus_one");
      run_op(32'h3F800000, 32'h3F800000, 32'h00000000, 3, "one_minus_one");
      run_op(32'hBF800000, 32'hBF800000, 32'h00000000, 3, "neg_cancel");
      run_op(32'h3F800000, 32'hBF800000, 32'h40000000, 4, "carry_path");
      run_op(32'h40000000, 32'h40400000, 32'hBF800000, 5, "two_minus_three");
      run_op(32'h40A00000, 32'h00000000, 32'h40A00000, 4, "minus_zero");
      run_op(32'h00000000, 32'h40A00000, 32'hC0A00000, 4, "zero_minus");
   endtask

   task automatic test_boundaries;
      run_op(32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 27, "k23_worst");
      run_op(32'h3F800000, 32'h30800000, 32'h3F800000, 4, "shift_sat");
      run_op(32'h3F800000, 32'hB4000000, 32'h3F800001, 4, "shift_23");
      run_op(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4, "overflow_pos");
      run_op(32'hFF7FFFFF, 32'h7F7FFFFF, 32'hFF800000, 4, "overflow_neg");
      run_op(32'h00800001, 32'h00800000, 32'h00000000, 4, "underflow_flush");
      run_op(32'h80800001, 32'h80800000, 32'h80000000, 4, "underflow_neg");
   endtask

   task automatic test_ignore_start;
      issue(32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 27, "ignore_start");
      collect(5, 32'h40400000, 32'h3F800000);
      expect_quiet(40, "ignore_start_extra_done");
   endtask

   task automatic test_reset_abort;
      exp_t dropped;
      issue(32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 27, "aborted");
      dropped = sb.pop_front();
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL abort_busy: got %b expected 0 (%s)", busy, dropped.name);
      end
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL abort_done: got %b expected 0", done);
      end
      tests++;
      if (result !== 32'h0) begin
         fails++;
         $display("FAIL abort_result: got %h expected 00000000", result);
      end
      expect_quiet(40, "abort_no_done");
      run_op(32'h40000000, 32'h40400000, 32'hBF800000, 5, "after_abort");
   endtask

   task automatic test_back_to_back;
      run_op(32'h40400000, 32'h3F800000, 32'h40000000, 4, "b2b_first");
      run_op(32'h3F800000, 32'hBF800000, 32'h40000000, 4, "b2b_second");
      run_op(32'h40000000, 32'h40400000, 32'hBF800000, 5, "b2b_third");
      repeat (5) @(posedge clk);
      #1;
      tests++;
      if (result !== 32'hBF800000) begin
         fails++;
         $display("FAIL result_hold: got %h expected bf800000", result);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_boundaries;
      test_ignore_start;
      test_reset_abort;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
